// File: rtl/partition_pkg.sv
// Shared constants for the partition scheduler: phase encodings and
// default parameter values used by the top and the FIFO.
package partition_pkg;

   localparam logic MODE_L = 1'b0;
   localparam logic MODE_H = 1'b1;

   localparam int DEFAULT_PERIOD = 10;
   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_DEPTH  = 4;

endpackage

// File: rtl/partition_fifo.sv
// Secret-data FIFO for the partition scheduler. It holds the storage,
// pointers and occupancy count. Push and pop are protected against full
// and empty here as well, so the count can never leave 0..DEPTH. A scrub
// pulse zeroes the storage and clears the pointers and the count.
module partition_fifo
   import partition_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             scrub,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and count; scrub has the final say
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (scrub) begin
         mem_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   // State registers; reset empties the FIFO and zeroes the storage
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/partition_scheduler.sv
// Time-partitioned scheduler. A free-running countdown alternates between
// an L phase and an H phase, each PERIOD+1 cycles long. The timer and the
// mode depend only on reset and elapsed cycles, so nothing on the H side
// can modulate them. The secret FIFO is only open in the H phase, and the
// timer==0 cycle is a guard cycle in which both handshakes are closed.
// Optional macro PARTITION_SCRUB_EN: wipes the FIFO on the H->L edge.
// Without it, queued words are kept and resume draining in the next H phase.
module partition_scheduler
   import partition_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int PERIOD = DEFAULT_PERIOD,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] timer,
   output logic             mode,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] data,
   output logic             data_valid,
   input  logic             data_ready
);

   logic [WIDTH-1:0] timer_q, timer_d;
   logic             mode_q, mode_d;
   logic             timer_zero;
   logic             window_open;
   logic             fifo_full, fifo_empty;
   logic             push, pop, scrub;
   logic [WIDTH-1:0] fifo_rdata;

   assign timer_zero = (timer_q == '0);

   // Countdown with reload; the phase flips on the reload edge
   always_comb begin
      timer_d = timer_q - WIDTH'(1);
      mode_d  = mode_q;
      if (timer_zero) begin
         timer_d = WIDTH'(PERIOD);
         mode_d  = (mode_q == MODE_H) ? MODE_L : MODE_H;
      end
   end

   // Phase registers; they see only reset and the clock
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= WIDTH'(PERIOD);
         mode_q  <= MODE_L;
      end else begin
         timer_q <= timer_d;
         mode_q  <= mode_d;
      end
   end

   // Handshake gating: open only in H phase and outside the guard cycle
   always_comb begin
      window_open = (mode_q == MODE_H) && !timer_zero;
      in_ready    = window_open && !fifo_full;
      data_valid  = window_open && !fifo_empty;
      data        = data_valid ? fifo_rdata : '0;
      push        = in_valid && in_ready;
      pop         = data_valid && data_ready;
   end

`ifdef PARTITION_SCRUB_EN
   // The H->L edge is the last H-phase cycle with timer at zero
   assign scrub = (mode_q == MODE_H) && timer_zero;
`else
   assign scrub = 1'b0;
`endif

   assign timer = timer_q;
   assign mode  = mode_q;

   partition_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .scrub (scrub),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_partition_scheduler.sv
// Directed bench for partition_scheduler with default parameters
// (WIDTH=16, PERIOD=10, DEPTH=4). Inputs are driven and outputs are
// sampled 1 time unit after the rising edge.
module tb_partition_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] timer;
   logic        mode;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] data;
   logic        data_valid;
   logic        data_ready;

   int n_chk = 0;
   int n_err = 0;

   partition_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .timer      (timer),
      .mode       (mode),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the bench at cycle 0: L phase, timer = 10
   task automatic do_reset();
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      data_ready = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   // Idle trace per cycle index after reset release
   function automatic logic [15:0] exp_timer(input int c);
      return 16'(10 - (c % 11));
   endfunction

   function automatic logic exp_mode(input int c);
      return 1'((c / 11) % 2);
   endfunction

   initial begin
      // Reset values and idle phase trace
      do_reset();
      chk("rst_timer", timer, 10);
      chk("rst_mode", mode, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_data", data, 0);
      for (int c = 0; c < 30; c++) begin
         chk($sformatf("idle_timer_c%0d", c), timer, exp_timer(c));
         chk($sformatf("idle_mode_c%0d", c), mode, exp_mode(c));
         if (exp_mode(c) == 1'b0 || exp_timer(c) == 0) begin
            chk($sformatf("idle_closed_c%0d", c), in_ready, 0);
         end else begin
            chk($sformatf("idle_open_c%0d", c), in_ready, 1);
         end
         step(1);
      end

      // Fill to full, reject a fifth word, then drain in order
      do_reset();
      step(11);
      chk("fill_h_mode", mode, 1);
      chk("fill_empty_ready", in_ready, 1);
      chk("fill_empty_dv", data_valid, 0);
      in_valid = 1'b1;
      in_data  = 16'h1111;
      step(1);
      chk("fill_first_dv", data_valid, 1);
      chk("fill_first_data", data, 16'h1111);
      in_data = 16'h2222; step(1);
      in_data = 16'h3333; step(1);
      in_data = 16'h4444; step(1);
      chk("fill_full_ready", in_ready, 0);
      in_data = 16'h5555; step(1);
      in_valid = 1'b0;
      chk("fill_head_kept", data, 16'h1111);
      data_ready = 1'b1;
      step(1); chk("drain_1", data, 16'h2222);
      step(1); chk("drain_2", data, 16'h3333);
      step(1); chk("drain_3", data, 16'h4444);
      step(1);
      chk("drain_empty_dv", data_valid, 0);
      chk("drain_empty_data", data, 0);
      chk("drain_timer", timer, 1);
      data_ready = 1'b0;

      // Simultaneous push and pop with two words queued
      do_reset();
      step(11);
      in_valid = 1'b1;
      in_data  = 16'h0101; step(1);
      in_data  = 16'h0202; step(1);
      in_data    = 16'hAAAA;
      data_ready = 1'b1;
      chk("pp_head_before", data, 16'h0101);
      step(1);
      in_valid   = 1'b0;
      data_ready = 1'b0;
      chk("pp_head_after", data, 16'h0202);
      chk("pp_ready", in_ready, 1);
      data_ready = 1'b1;
      step(1); chk("pp_second", data, 16'hAAAA);
      step(1); chk("pp_empty", data_valid, 0);
      data_ready = 1'b0;

      // Push on the last open cycle, then cross the guard and L phase
      do_reset();
      step(20);
      chk("late_timer", timer, 1);
      chk("late_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = 16'h5A5A;
      step(1);
      in_valid = 1'b0;
      chk("guard_timer", timer, 0);
      chk("guard_dv", data_valid, 0);
      chk("guard_ready", in_ready, 0);
      chk("guard_data", data, 0);
      step(1);
      chk("lphase_mode", mode, 0);
      chk("lphase_dv", data_valid, 0);
      step(11);
      chk("next_h_mode", mode, 1);
      chk("next_h_timer", timer, 10);
`ifdef PARTITION_SCRUB_EN
      chk("scrub_dv", data_valid, 0);
      chk("scrub_data", data, 0);
`else
      chk("retain_dv", data_valid, 1);
      chk("retain_data", data, 16'h5A5A);
`endif

      // Reset mid-phase with three words queued and a push/pop pending
      do_reset();
      step(11);
      in_valid = 1'b1;
      in_data = 16'h0A0A; step(1);
      in_data = 16'h0B0B; step(1);
      in_data = 16'h0C0C; step(1);
      chk("mid_dv", data_valid, 1);
      data_ready = 1'b1;
      reset      = 1'b1;
      step(1);
      chk("mid_rst_mode", mode, 0);
      chk("mid_rst_timer", timer, 10);
      chk("mid_rst_data", data, 0);
      chk("mid_rst_dv", data_valid, 0);
      reset      = 1'b0;
      in_valid   = 1'b0;
      data_ready = 1'b0;
      step(11);
      chk("mid_empty_mode", mode, 1);
      chk("mid_empty_dv", data_valid, 0);
      chk("mid_empty_ready", in_ready, 1);

      // Random H-side activity must not disturb the phase trace
      do_reset();
      for (int c = 0; c < 100; c++) begin
         chk($sformatf("rnd_timer_c%0d", c), timer, exp_timer(c));
         chk($sformatf("rnd_mode_c%0d", c), mode, exp_mode(c));
         if (exp_mode(c) == 1'b0 || exp_timer(c) == 0) begin
            chk($sformatf("rnd_closed_ir_c%0d", c), in_ready, 0);
            chk($sformatf("rnd_closed_dv_c%0d", c), data_valid, 0);
         end
         in_valid   = 1'($urandom_range(0, 1));
         data_ready = 1'($urandom_range(0, 1));
         in_data    = 16'($urandom);
         step(1);
      end
      in_valid   = 1'b0;
      data_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/partition_scheduler.md
PARTITION_SCHEDULER -- requirements
Module: partition_scheduler

Interface
REQ-001 Parameter WIDTH, default 16: data and timer width in bits.
REQ-002 Parameter PERIOD, default 10: reload value of the phase countdown.
REQ-003 Parameter DEPTH, default 4 (power of two): secret-data FIFO entries.
REQ-004 Port clk, input, 1, label L: single clock; all state updates on posedge clk.
REQ-005 Port reset, input, 1, label L: synchronous, active-high reset, sampled on posedge clk.
REQ-006 Port timer, output, WIDTH, label L: phase countdown value.
REQ-007 Port mode, output, 1, label L: phase indicator; 0 = L phase, 1 = H phase.
REQ-008 Port in_data, input, WIDTH, label H: secret producer data.
REQ-009 Port in_valid, input, 1, label H: producer offers in_data.
REQ-010 Port in_ready, output, 1, label H: FIFO accepts a word this cycle.
REQ-011 Port data, output, WIDTH, label H: FIFO head word presented to the downstream state machine.
REQ-012 Port data_valid, output, 1, label H: data holds a valid word.
REQ-013 Port data_ready, input, 1, label H: consumer takes data this cycle.

Function
REQ-014 Timer SHALL decrement by 1 each cycle; when timer == 0, it SHALL reload to PERIOD and mode SHALL toggle on the next edge; the phase length is PERIOD+1 cycles.
REQ-015 Timer and mode SHALL depend only on reset and elapsed cycles, never on any H-labelled signal.
REQ-016 Phase sequence SHALL be L_PHASE -> H_PHASE -> L_PHASE ..., with no other states.
REQ-017 Guard cycle: when timer == 0, in_ready and data_valid SHALL both be 0.
REQ-018 in_ready SHALL be 1 only if mode == 1, timer != 0, and the FIFO is not full.
REQ-019 A push SHALL occur iff in_valid && in_ready; in_data SHALL be written at the tail.
REQ-020 data_valid SHALL be 1 only if mode == 1, timer != 0, and the FIFO is not empty.
REQ-021 When data_valid == 0, data SHALL drive 0.
REQ-022 A pop SHALL occur iff data_valid && data_ready.
REQ-023 Simultaneous push and pop SHALL leave the count unchanged, with FIFO order preserved.
REQ-024 When full, no push; there is no write-through bypass.
REQ-025 When empty, no pop; a pushed word SHALL first appear on data the following cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 The count SHALL range over 0..DEPTH and SHALL never overflow or underflow.
REQ-028 During L phase, FIFO contents SHALL be frozen; only REQ-034 may modify them.

Reset
REQ-029 On reset: timer = PERIOD, mode = 0, FIFO empty, storage zeroed.
REQ-030 On reset: in_ready = 0, data_valid = 0, data = 0.
REQ-031 Reset asserted mid-phase SHALL override any push or pop in that cycle.
REQ-032 The first cycle after reset deassertion SHALL be L phase with timer = PERIOD.

Configuration
REQ-033 Macro PARTITION_SCRUB_EN SHALL control FIFO scrubbing at the H->L transition.
REQ-034 With PARTITION_SCRUB_EN defined, on the edge where mode goes 1->0, all FIFO storage SHALL be zeroed and the count and pointers cleared.
REQ-035 With PARTITION_SCRUB_EN undefined, FIFO contents SHALL be retained and SHALL resume draining in the next H phase.

Structure
REQ-036 Shared package partition_pkg SHALL hold MODE_L = 0, MODE_H = 1, DEFAULT_PERIOD = 10, and DEFAULT_WIDTH = 16.
REQ-037 Storage and pointers SHALL reside in sub-module partition_fifo (push, pop, full, empty, scrub inputs/outputs).
REQ-038 Timer, mode, and gating logic SHALL reside in partition_scheduler.

Verification
REQ-039 Reset, then run 30 cycles: mode = 0 for cycles 0-10, 1 for cycles 11-21, 0 from cycle 22; timer reads 10..0 in each phase.
REQ-040 In H phase, push 0x1111, 0x2222, 0x3333, 0x4444 with data_ready = 0: count reaches 4, in_ready drops to 0, and a fifth word is rejected.
REQ-041 In H phase, with FIFO holding 2 words, push 0xAAAA and pop in the same cycle: count stays 2, pops return the old head first, then 0xAAAA.
REQ-042 Push 0x5A5A on the timer == 1 cycle of H phase: the guard cycle shows data_valid = 0; with scrub enabled, next H phase is empty; with scrub disabled, next H phase presents data = 0x5A5A.
REQ-043 Assert reset with 3 words queued in H phase: the next cycle shows mode = 0, timer = 10, data = 0, data_valid = 0, FIFO empty.
REQ-044 Toggle in_data/in_valid randomly for 100 cycles: the timer and mode trace is identical to the idle run.
